// File: rtl/register_file_sequencer_pkg.sv
// Shared types for the register-file command sequencer: opcodes, FSM states
// and default datapath widths.
package register_file_sequencer_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/register_file_4.sv
// Four-entry register file: two combinational read ports, one synchronous
// write port. Contents are deliberately not reset so an aborted write is visible.
module register_file_4 #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_reg_read_0,
  input  logic [ADDR_W-1:0] i_reg_read_1,
  input  logic [ADDR_W-1:0] i_reg_write,
  input  logic [DATA_W-1:0] i_port_write,
  input  logic              i_write_enable,
  output logic [DATA_W-1:0] o_port_read_0,
  output logic [DATA_W-1:0] o_port_read_1
);

  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [DATA_W-1:0] regs_d [2**ADDR_W];

  always_comb begin
    regs_d = regs_q;
    if (i_write_enable) regs_d[i_reg_write] = i_port_write;
  end

  always_ff @(posedge i_clk) begin
    regs_q <= regs_d;
  end

  assign o_port_read_0 = regs_q[i_reg_read_0];
  assign o_port_read_1 = regs_q[i_reg_read_1];

endmodule

// File: rtl/register_file_sequencer_alu_4.sv
// Combinational ALU used in the EXEC step: result, carry/no-borrow and zero.
module alu_4
  import register_file_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  localparam logic [DATA_W:0] ONE = (DATA_W+1)'(1);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // Two's-complement subtract: carry out is the unsigned "no borrow" flag.
      OP_SUB, OP_CMP: begin
        sum    = {1'b0, a} + {1'b0, ~b} + ONE;
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/register_file_sequencer.sv
// Four-step command sequencer (IDLE/READ/EXEC/WRITE) driving a register file:
// reads two sources, runs the ALU, writes the result back.
module register_file_sequencer
  import register_file_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_rs0,
  input  logic [ADDR_W-1:0] i_cmd_rs1,
  input  logic [ADDR_W-1:0] i_cmd_rd,
  input  logic [DATA_W-1:0] i_cmd_imm,
  output logic [ADDR_W-1:0] o_reg_read_0,
  output logic [ADDR_W-1:0] o_reg_read_1,
  input  logic [DATA_W-1:0] i_port_read_0,
  input  logic [DATA_W-1:0] i_port_read_1,
  output logic [ADDR_W-1:0] o_reg_write,
  output logic [DATA_W-1:0] o_port_write,
  output logic              o_write_enable,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_done
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] rs0_q, rs0_d, rs1_q, rs1_d, rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d, opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d, zero_q, zero_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero;

  alu_4 #(.DATA_W(DATA_W)) u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs0_d    = rs0_q;
    rs1_d    = rs1_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          op_d    = op_e'(i_cmd_op);
          rs0_d   = i_cmd_rs0;
          rs1_d   = i_cmd_rs1;
          rd_d    = i_cmd_rd;
          imm_d   = i_cmd_imm;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = i_port_read_0;
        opb_d   = i_port_read_1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_result;
        carry_d  = alu_carry;
        zero_d   = alu_zero;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rs0_q    <= '0;
      rs1_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // Reset is combinationally folded in so a reset during WRITE kills that write.
  assign o_cmd_ready    = (state_q == S_IDLE);
  assign o_write_enable = (state_q == S_WRITE) && (op_q != OP_CMP) && !i_reset;
  assign o_done         = (state_q == S_WRITE) && !i_reset;
  assign o_reg_read_0   = rs0_q;
  assign o_reg_read_1   = rs1_q;
  assign o_reg_write    = rd_q;
  assign o_port_write   = result_q;
  assign o_result       = result_q;
  assign o_carry        = carry_q;
  assign o_zero         = zero_q;

endmodule

// File: doc/register_file_sequencer.md
Name: register_file_sequencer

Overview:
Multi-cycle command sequencer that sits directly in front of register_file_4. It accepts one ALU command per valid/ready handshake and drives the file's two read-port selects. It captures the operands, computes a 4-bit result with flags, and writes the result back through the write port with a single-cycle write enable. It replaces the raw switch/push-button drive of the register file and turns the pair into a tiny datapath.

Parameters:
DATA_W, 4, data width of register file ports and ALU
ADDR_W, 2, register select width (2**ADDR_W registers)

Ports:
i_clk  in  1  system clock; all state updates on rising edge
i_reset  in  1  reset; synchronous, active-high
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  sequencer can accept a command (IDLE only)
i_cmd_op  in  3  operation, see Behaviour
i_cmd_rs0  in  ADDR_W  first source register
i_cmd_rs1  in  ADDR_W  second source register
i_cmd_rd  in  ADDR_W  destination register
i_cmd_imm  in  DATA_W  immediate for LDI
o_reg_read_0  out  ADDR_W  to register file i_reg_read_0
o_reg_read_1  out  ADDR_W  to register file i_reg_read_1
i_port_read_0  in  DATA_W  from register file o_port_read_0 (combinational read)
i_port_read_1  in  DATA_W  from register file o_port_read_1
o_reg_write  out  ADDR_W  to register file i_reg_write
o_port_write  out  DATA_W  to register file i_port_write
o_write_enable  out  1  to register file i_write_enable
o_result  out  DATA_W  last computed result
o_carry  out  1  carry / no-borrow flag of last command
o_zero  out  1  result==0 flag of last command
o_done  out  1  one-cycle pulse when a command completes

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (rd=rs0), 110 LDI (rd=imm), 111 CMP (SUB flags only, no write).
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE: o_cmd_ready=1. On valid&ready, latch op/rs0/rs1/rd/imm and go to READ.
  - READ: read selects driven from the latched rs0/rs1; operands registered at end of cycle; go to EXEC.
  - EXEC: ALU result and flags registered into o_result/o_carry/o_zero; go to WRITE.
  - WRITE: o_write_enable=1 (0 for CMP); o_reg_write=latched rd; o_port_write=o_result; o_done=1; go to IDLE.
- Latency: handshake at edge k; write enable and o_done high in cycle k+3; ready again in cycle k+4. Throughput is 1 command per 4 cycles.
- Read selects hold latched rs0/rs1 outside READ as well (stable, no glitches). In IDLE they show the last command's values.
- Arithmetic: ADD carry = bit DATA_W of zero-extended sum. SUB/CMP compute a + ~b + 1, so carry=1 iff a>=b (unsigned). Logic ops, MOV and LDI clear carry. Zero = (result==0) for every op. Results wrap modulo 2**DATA_W.
- Hazards: a write lands at the WRITE edge, before the next READ, so back-to-back dependent commands always see the new value. rd==rs0==rs1 is legal.
- i_cmd_valid outside IDLE is ignored. Command fields are sampled only at the handshake edge.
- Reset values: state=IDLE; latched fields=0; o_result=0; o_carry=0; o_zero=0; o_done=0; o_write_enable=0.
- o_write_enable = (state==WRITE) && op!=CMP && !i_reset. Reset asserted during WRITE therefore suppresses that write in the same cycle. Reset in any other state aborts the command with no register modified.
- Reset is not gated by valid; a valid held through reset is accepted in the first IDLE cycle after release.

Decomposition:
- Package register_file_sequencer_pkg: op_e enum (3-bit opcodes above), state_e enum, DATA_W/ADDR_W defaults.
- One combinational sub-module alu_4: inputs a, b, imm, op; outputs result, carry, zero. It is instantiated once in EXEC datapath.
- Bench instantiates sequencer + register_file_4 together.

Test Plan:
- Reset, then LDI r1=4'h9 -> o_done and o_write_enable high exactly 3 cycles after handshake, r1 reads 9, o_zero=0, o_carry=0.
- LDI r0=7, r1=9, then ADD rd=r2 rs0=r0 rs1=r1 -> r2=0 (16 mod 16), o_carry=1, o_zero=1.
- SUB r3=r0-r1 (7-9) -> r3=4'hE, carry=0. CMP r1,r0 -> carry=1, zero=0, write enable never asserts, r0..r3 unchanged.
- Back-to-back: ADD r1=r1+r1, valid held continuously, then XOR r2=r1^r0 -> the second command sees the updated r1, each completes 4 cycles apart, o_cmd_ready low for 3 cycles per command.
- Reset asserted in the WRITE cycle of LDI r2=5 -> o_write_enable stays 0, r2 keeps its old value, FSM is in IDLE with ready=1 on the cycle after reset drops.
- i_cmd_valid pulsed while busy (READ/EXEC) with different fields -> ignored, latched command completes unaltered.
